// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchronizer, debounce filter,
// rise/fall pulse generation with per-channel enables, and sticky event flags.
module multi_edge_detector #(
   parameter int NCH         = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       sig_in,
   input  logic [DEB_W-1:0]     deb_len,
   input  logic [2*NCH-1:0]     mode,
   input  logic [NCH-1:0]       flag_clr,
   output logic [NCH-1:0]       rise_pulse,
   output logic [NCH-1:0]       fall_pulse,
   output logic [NCH-1:0]       event_flag,
   output logic                 irq
);

   genvar ch;
   generate
      for (ch = 0; ch < NCH; ch++) begin : gen_ch
         logic [SYNC_STAGES-1:0] sync_q;
         logic                   sync_bit;
         logic                   filt_q;
         logic [DEB_W-1:0]       cnt_q;
         logic                   mism;
         logic                   accept;
         logic                   rise_set;
         logic                   fall_set;
         logic                   rise_q;
         logic                   fall_q;
         logic                   flag_q;

         assign sync_bit = sync_q[SYNC_STAGES-1];
         assign mism     = sync_bit ^ filt_q;
         // A lowered deb_len below an in-progress count accepts at once
         assign accept   = mism && (cnt_q >= deb_len);
         assign rise_set = accept &  sync_bit & mode[2*ch];
         assign fall_set = accept & ~sync_bit & mode[2*ch+1];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q <= '0;
               filt_q <= 1'b0;
               cnt_q  <= '0;
               rise_q <= 1'b0;
               fall_q <= 1'b0;
               flag_q <= 1'b0;
            end else begin
               sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[ch]};
               if (!mism) begin
                  cnt_q <= '0;
               end else if (accept) begin
                  filt_q <= sync_bit;
                  cnt_q  <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
               rise_q <= rise_set;
               fall_q <= fall_set;
               // Set has priority over a coincident clear
               flag_q <= rise_set | fall_set | (flag_q & ~flag_clr[ch]);
            end
         end

         assign rise_pulse[ch] = rise_q;
         assign fall_pulse[ch] = fall_q;
         assign event_flag[ch] = flag_q;
      end
   endgenerate

   assign irq = |event_flag;

endmodule
